// File: rtl/i2c_reg_master.sv
// ---------------------------------------------------------------------------
// i2c_reg_master
// Single-master I2C controller for register-style transfers:
//   write: START, dev+W, reg address bytes, data bytes, STOP
//   read : START, dev+W, reg address bytes, RESTART, dev+R, data bytes, STOP
// Every bit time is four quarters of CLK_DIV clocks each. SCL is released
// in q2..q3, SDA changes at the q0 boundary and is sampled at the q2->q3
// boundary. A slave holding SCL low while it is released freezes the
// quarter counter (clock stretching).
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   start_i            one-cycle request, only accepted in IDLE
//   rnw_i              1 = read, 0 = write (sampled with start_i)
//   dev_addr_i         7-bit device address (sampled with start_i)
//   reg_addr_i         register address, MSB byte first (sampled with start_i)
//   wdata_i            write data, MSB byte first (sampled with start_i)
//   rdata_o            read data, first byte received in the MSB position
//   busy_o, done_o     transaction in progress / one-cycle end pulse
//   nack_o             last transaction was aborted by a slave NACK
//   scl_i, sda_i       synchronised pad inputs
//   scl_oe_o, sda_oe_o open-drain controls, 1 = pull the line low
//   state_o            current FSM state, for debug and checkers
//
// Handshake: start_i is a request without a ready; it is taken only when
// busy_o is low, and a request while busy_o is high is dropped.
// ---------------------------------------------------------------------------
module i2c_reg_master #(
    parameter int CLK_DIV    = 4,
    parameter int ADDR_BYTES = 1,
    parameter int DATA_BYTES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    rnw_i,
    input  logic [6:0]              dev_addr_i,
    input  logic [8*ADDR_BYTES-1:0] reg_addr_i,
    input  logic [8*DATA_BYTES-1:0] wdata_i,
    output logic [8*DATA_BYTES-1:0] rdata_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    nack_o,
    input  logic                    scl_i,
    input  logic                    sda_i,
    output logic                    scl_oe_o,
    output logic                    sda_oe_o,
    output logic [3:0]              state_o
);
    localparam int AW = 8 * ADDR_BYTES;
    localparam int DW = 8 * DATA_BYTES;
    localparam logic [9:0] DIV_LAST = 10'(CLK_DIV - 1);
    localparam logic [1:0] AB_LAST  = 2'(ADDR_BYTES - 1);
    localparam logic [1:0] DB_LAST  = 2'(DATA_BYTES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDRESS, S_REGADDRESS, S_WRITE,
        S_RESTART, S_READ, S_ACK, S_MACK, S_STOP
    } state_t;

    state_t          state_q, state_d, phase_q, phase_d;
    logic            rd_phase_q, rd_phase_d;   // second address (dev+R) of a read
    logic [1:0]      qtr_q, qtr_d;
    logic [9:0]      div_q, div_d;
    logic [2:0]      bit_q, bit_d;
    logic [1:0]      byte_q, byte_d;
    logic [7:0]      sh_q, sh_d;
    logic            rnw_q, rnw_d;
    logic [6:0]      dev_q, dev_d;
    logic [AW-1:0]   reg_q, reg_d;
    logic [DW-1:0]   wdat_q, wdat_d, rbuf_q, rbuf_d, rdata_q, rdata_d;
    logic            busy_q, busy_d, done_q, done_d, nack_q, nack_d;
    logic            scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;
    logic            stall, tick, samp, bit_end;

    // SCL released by us but still seen low: a slave is stretching.
    assign stall   = (state_q != S_IDLE) && !scl_oe_q && !scl_i;
    assign tick    = !stall && (div_q == DIV_LAST);
    assign samp    = tick && (qtr_q == 2'd2);
    assign bit_end = tick && (qtr_q == 2'd3);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        rd_phase_d = rd_phase_q;
        qtr_d      = qtr_q;
        div_d      = div_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        sh_d       = sh_q;
        rnw_d      = rnw_q;
        dev_d      = dev_q;
        reg_d      = reg_q;
        wdat_d     = wdat_q;
        rbuf_d     = rbuf_q;
        rdata_d    = rdata_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        nack_d     = nack_q;

        if (state_q != S_IDLE && !stall) begin
            div_d = tick ? 10'd0 : div_q + 10'd1;
            if (tick) qtr_d = qtr_q + 2'd1;
        end

        case (state_q)
            S_IDLE: if (start_i) begin
                state_d    = S_START;
                busy_d     = 1'b1;
                nack_d     = 1'b0;
                rnw_d      = rnw_i;
                dev_d      = dev_addr_i;
                reg_d      = reg_addr_i;
                wdat_d     = wdata_i;
                rd_phase_d = 1'b0;
                div_d      = 10'd0;
                qtr_d      = 2'd0;
                bit_d      = 3'd0;
                byte_d     = 2'd0;
            end
            S_START: if (bit_end) begin
                state_d = S_ADDRESS;
                sh_d    = {dev_q, rd_phase_q};
            end
            S_ADDRESS, S_REGADDRESS, S_WRITE: if (bit_end) begin
                sh_d  = {sh_q[6:0], 1'b0};
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    state_d = S_ACK;
                    phase_d = state_q;
                end
            end
            S_ACK: begin
                if (samp && sda_i) nack_d = 1'b1;
                if (bit_end) begin
                    if (nack_q) begin
                        state_d = S_STOP;
                    end else begin
                        case (phase_q)
                            S_ADDRESS: begin
                                byte_d = 2'd0;
                                if (rd_phase_q) begin
                                    state_d = S_READ;
                                end else begin
                                    state_d = S_REGADDRESS;
                                    sh_d    = reg_q[AW-1 -: 8];
                                    reg_d   = reg_q << 8;
                                end
                            end
                            S_REGADDRESS: begin
                                if (byte_q != AB_LAST) begin
                                    state_d = S_REGADDRESS;
                                    byte_d  = byte_q + 2'd1;
                                    sh_d    = reg_q[AW-1 -: 8];
                                    reg_d   = reg_q << 8;
                                end else if (rnw_q) begin
                                    state_d = S_RESTART;
                                end else begin
                                    state_d = S_WRITE;
                                    byte_d  = 2'd0;
                                    sh_d    = wdat_q[DW-1 -: 8];
                                    wdat_d  = wdat_q << 8;
                                end
                            end
                            default: begin  // acknowledge of a data byte
                                if (byte_q == DB_LAST) begin
                                    state_d = S_STOP;
                                end else begin
                                    state_d = S_WRITE;
                                    byte_d  = byte_q + 2'd1;
                                    sh_d    = wdat_q[DW-1 -: 8];
                                    wdat_d  = wdat_q << 8;
                                end
                            end
                        endcase
                    end
                end
            end
            // The repeated START condition is built into this bit time,
            // so the device address follows directly.
            S_RESTART: if (bit_end) begin
                state_d    = S_ADDRESS;
                rd_phase_d = 1'b1;
                sh_d       = {dev_q, 1'b1};
            end
            S_READ: begin
                if (samp) rbuf_d = {rbuf_q[DW-2:0], sda_i};
                if (bit_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_MACK;
                end
            end
            S_MACK: if (bit_end) begin
                if (byte_q == DB_LAST) begin
                    state_d = S_STOP;
                end else begin
                    state_d = S_READ;
                    byte_d  = byte_q + 2'd1;
                end
            end
            S_STOP: if (bit_end) begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (rnw_q && !nack_q) rdata_d = rbuf_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line drive as a function of state and quarter; registered, so both
    // lines move together one clock after the quarter changes.
    always_comb begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
        case (state_q)
            S_START: begin
                scl_oe_d = (qtr_q == 2'd3);
                sda_oe_d = qtr_q[1];
            end
            S_ADDRESS, S_REGADDRESS, S_WRITE: begin
                scl_oe_d = !qtr_q[1];
                sda_oe_d = !sh_q[7];
            end
            S_ACK, S_READ: scl_oe_d = !qtr_q[1];
            S_MACK: begin
                scl_oe_d = !qtr_q[1];
                sda_oe_d = (byte_q != DB_LAST);  // NACK only the last byte
            end
            S_RESTART: begin
                scl_oe_d = (qtr_q == 2'd0) || (qtr_q == 2'd3);
                sda_oe_d = qtr_q[1];
            end
            S_STOP: begin
                scl_oe_d = (qtr_q == 2'd0);
                sda_oe_d = (qtr_q != 2'd3);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            phase_q    <= S_IDLE;
            rd_phase_q <= 1'b0;
            qtr_q      <= 2'd0;
            div_q      <= 10'd0;
            bit_q      <= 3'd0;
            byte_q     <= 2'd0;
            sh_q       <= 8'd0;
            rnw_q      <= 1'b0;
            dev_q      <= 7'd0;
            reg_q      <= '0;
            wdat_q     <= '0;
            rbuf_q     <= '0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            nack_q     <= 1'b0;
            scl_oe_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            rd_phase_q <= rd_phase_d;
            qtr_q      <= qtr_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            sh_q       <= sh_d;
            rnw_q      <= rnw_d;
            dev_q      <= dev_d;
            reg_q      <= reg_d;
            wdat_q     <= wdat_d;
            rbuf_q     <= rbuf_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            nack_q     <= nack_d;
            scl_oe_q   <= scl_oe_d;
            sda_oe_q   <= sda_oe_d;
        end
    end

    assign rdata_o  = rdata_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign nack_o   = nack_q;
    assign scl_oe_o = scl_oe_q;
    assign sda_oe_o = sda_oe_q;
    assign state_o  = state_q;
endmodule

// File: tb/tb_i2c_reg_master.sv
// Bench for i2c_reg_master. Two instances share one open-drain bus with a
// behavioural slave at address 0x50: u_m1 (1 address byte, 1 data byte)
// and u_m2 (2 address bytes, 2 data bytes). Only one master is active at a
// time; the idle one releases both lines.
module tb_i2c_reg_master;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        rst1, rst2, start1, start2, rnw1, rnw2;
  logic [6:0]  dev1, dev2;
  logic [7:0]  reg1, wd1, rdata1;
  logic [15:0] reg2, wd2, rdata2;
  logic        busy1, done1, nack1, scl_oe1, sda_oe1;
  logic        busy2, done2, nack2, scl_oe2, sda_oe2;
  logic [3:0]  st1, st2;
  logic        scl_b, sda_b;

  i2c_reg_master #(.CLK_DIV(4), .ADDR_BYTES(1), .DATA_BYTES(1)) u_m1 (
    .clk(clk), .rst(rst1), .start_i(start1), .rnw_i(rnw1), .dev_addr_i(dev1),
    .reg_addr_i(reg1), .wdata_i(wd1), .rdata_o(rdata1), .busy_o(busy1),
    .done_o(done1), .nack_o(nack1), .scl_i(scl_b), .sda_i(sda_b),
    .scl_oe_o(scl_oe1), .sda_oe_o(sda_oe1), .state_o(st1));

  i2c_reg_master #(.CLK_DIV(4), .ADDR_BYTES(2), .DATA_BYTES(2)) u_m2 (
    .clk(clk), .rst(rst2), .start_i(start2), .rnw_i(rnw2), .dev_addr_i(dev2),
    .reg_addr_i(reg2), .wdata_i(wd2), .rdata_o(rdata2), .busy_o(busy2),
    .done_o(done2), .nack_o(nack2), .scl_i(scl_b), .sda_i(sda_b),
    .scl_oe_o(scl_oe2), .sda_oe_o(sda_oe2), .state_o(st2));

  // ---------------- slave model ----------------
  logic       s_drv = 1'b0, hold = 1'b0;
  logic       scl_p = 1'b1, sda_p = 1'b1, oe_p = 1'b0;
  logic       s_first = 1'b0, s_sel = 1'b0, s_rd = 1'b0, s_tx = 1'b0, s_mack = 1'b1;
  logic [7:0] s_sh = 8'd0, s_byte = 8'd0;
  logic [7:0] tx_bytes [4];
  int         s_cnt = 0, s_tx_idx = 0, hold_cnt = 0;
  int         rel_cnt = 0, stretch_at = -1, n_rise = 0, n_start = 0, n_stop = 0;
  logic [7:0] bus_q[$];     // bytes written by the master
  logic       mack_q[$];    // master ACK bits seen after slave bytes

  assign scl_b = ~(scl_oe1 | scl_oe2 | hold);
  assign sda_b = ~(sda_oe1 | sda_oe2 | s_drv);

  always @(negedge clk) begin
    logic oe_now, scl_now, sda_now;
    // Stretch: pull SCL low for 50 clocks from the chosen master release.
    oe_now = scl_oe1 | scl_oe2;
    if (oe_p && !oe_now) begin
      rel_cnt++;
      if (rel_cnt == stretch_at) hold_cnt = 50;
    end else if (hold_cnt > 0) begin
      hold_cnt--;
    end
    oe_p = oe_now;
    hold = (hold_cnt != 0);
    scl_now = ~(scl_oe1 | scl_oe2 | hold);
    sda_now = ~(sda_oe1 | sda_oe2 | s_drv);
    if (scl_p && scl_now && sda_p && !sda_now) begin
      n_start++; s_cnt = 0; s_first = 1'b1; s_tx = 1'b0; s_drv = 1'b0; s_tx_idx = 0;
    end else if (scl_p && scl_now && !sda_p && sda_now) begin
      n_stop++; s_cnt = 0; s_tx = 1'b0; s_drv = 1'b0; s_sel = 1'b0;
    end else if (!scl_p && scl_now) begin
      n_rise++;
      if (s_cnt < 8) begin
        if (!s_tx) s_sh = {s_sh[6:0], sda_now};
        s_cnt++;
      end else if (s_cnt == 8) begin
        if (s_tx) mack_q.push_back(sda_now);
        s_mack = sda_now;
        s_cnt = 9;
      end
    end else if (scl_p && !scl_now) begin
      if (s_cnt == 8) begin
        if (!s_tx) begin
          bus_q.push_back(s_sh);
          if (s_first) begin
            s_sel = (s_sh[7:1] == 7'h50);
            s_rd = s_sh[0];
            s_first = 1'b0;
          end
          s_drv = s_sel;
        end else begin
          s_drv = 1'b0;
        end
      end else if (s_cnt == 9) begin
        s_cnt = 0;
        s_drv = 1'b0;
        if (s_sel && s_rd && (!s_tx || !s_mack)) begin
          s_tx = 1'b1;
          s_byte = tx_bytes[s_tx_idx];
          s_tx_idx++;
          s_drv = ~s_byte[7];
        end else if (s_tx) begin
          s_tx = 1'b0;
          s_sel = 1'b0;
        end
      end else if (s_tx && s_cnt >= 1 && s_cnt <= 7) begin
        s_drv = ~s_byte[7 - s_cnt];
      end
    end
    scl_p = scl_now;
    sda_p = ~(sda_oe1 | sda_oe2 | s_drv);
  end

  // Cycle counters, sampled at the active edge (pre-update values).
  int busy1_cnt = 0, done1_cnt = 0, busy2_cnt = 0, done2_cnt = 0;
  always @(posedge clk) begin
    if (busy1) busy1_cnt++;
    if (done1) done1_cnt++;
    if (busy2) busy2_cnt++;
    if (done2) done2_cnt++;
  end

  // ---------------- scoreboard ----------------
  int tests = 0, fails = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bus(input string tag, input int base);
    check({tag, "_nbytes"}, 32'(bus_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < bus_q.size())
        check($sformatf("%s_byte%0d", tag, i), 32'(bus_q[base + i]), 32'(exp_q[i]));
    exp_q.delete();
  endtask

  task automatic wait_done(input bit which, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if ((which ? done2 : done1) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_start1(input logic r, input logic [6:0] d, input logic [7:0] ra,
                              input logic [7:0] wdat);
    rnw1 = r; dev1 = d; reg1 = ra; wd1 = wdat; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int bb, b1, d1, st0, sp0, rr, mb;
    bit ok;
    rst1 = 1'b1; rst2 = 1'b1; start1 = 1'b0; start2 = 1'b0;
    rnw1 = 1'b0; rnw2 = 1'b0; dev1 = 7'd0; dev2 = 7'd0;
    reg1 = 8'd0; reg2 = 16'd0; wd1 = 8'd0; wd2 = 16'd0;
    tx_bytes[0] = 8'hBE; tx_bytes[1] = 8'hEF; tx_bytes[2] = 8'h00; tx_bytes[3] = 8'h00;
    repeat (3) @(negedge clk);
    rst1 = 1'b0; rst2 = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_scl_oe", 32'(scl_oe1), 32'd0);
    check("rst_sda_oe", 32'(sda_oe1), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_nack", 32'(nack1), 32'd0);
    check("rst_state", 32'(st1), 32'd0);
    check("rst_rdata2", 32'(rdata2), 32'd0);

    // Write 0x50 / reg 0x12 / data 0xA5
    bb = bus_q.size(); b1 = busy1_cnt; d1 = done1_cnt; st0 = n_start; sp0 = n_stop;
    pulse_start1(1'b0, 7'h50, 8'h12, 8'hA5);
    check("wr_busy_rise", 32'(busy1), 32'd1);
    wait_done(1'b0, 2000, ok);
    check("wr_done_seen", 32'(ok), 32'd1);
    check("wr_busy_fall", 32'(busy1), 32'd0);
    @(negedge clk);
    check("wr_done_1cyc", 32'(done1), 32'd0);
    check("wr_idle_oe", 32'({scl_oe1, sda_oe1}), 32'd0);
    repeat (4) @(negedge clk);
    check("wr_busy_cycles", 32'(busy1_cnt - b1), 32'd464);
    check("wr_done_cycles", 32'(done1_cnt - d1), 32'd1);
    check("wr_nack", 32'(nack1), 32'd0);
    check("wr_starts", 32'(n_start - st0), 32'd1);
    check("wr_stops", 32'(n_stop - sp0), 32'd1);
    exp_q.push_back(8'hA0); exp_q.push_back(8'h12); exp_q.push_back(8'hA5);
    check_bus("wr", bb);

    // Read 2+2 bytes from 0x50 / reg 0x0102, slave returns 0xBE 0xEF
    bb = bus_q.size(); b1 = busy2_cnt; st0 = n_start; mb = mack_q.size();
    rnw2 = 1'b1; dev2 = 7'h50; reg2 = 16'h0102; wd2 = 16'h0000; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    wait_done(1'b1, 3000, ok);
    check("rd_done_seen", 32'(ok), 32'd1);
    check("rd_rdata", 32'(rdata2), 32'hBEEF);
    repeat (4) @(negedge clk);
    check("rd_busy_cycles", 32'(busy2_cnt - b1), 32'd912);
    check("rd_nack", 32'(nack2), 32'd0);
    check("rd_starts", 32'(n_start - st0), 32'd2);
    check("rd_mack_n", 32'(mack_q.size() - mb), 32'd2);
    if (mack_q.size() >= mb + 2) begin
      check("rd_mack0_ack", 32'(mack_q[mb]), 32'd0);
      check("rd_mack1_nack", 32'(mack_q[mb + 1]), 32'd1);
    end
    exp_q.push_back(8'hA0); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    exp_q.push_back(8'hA1);
    check_bus("rd", bb);

    // Address NACK: nobody at 0x33
    bb = bus_q.size(); b1 = busy2_cnt; rr = n_rise; sp0 = n_stop;
    rnw2 = 1'b1; dev2 = 7'h33; reg2 = 16'h5555; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    wait_done(1'b1, 3000, ok);
    check("nk_done_seen", 32'(ok), 32'd1);
    check("nk_nack", 32'(nack2), 32'd1);
    check("nk_rdata_held", 32'(rdata2), 32'hBEEF);
    repeat (4) @(negedge clk);
    check("nk_busy_cycles", 32'(busy2_cnt - b1), 32'd176);
    check("nk_scl_rises", 32'(n_rise - rr), 32'd10);
    check("nk_stops", 32'(n_stop - sp0), 32'd1);
    exp_q.push_back(8'h66);
    check_bus("nk", bb);

    // Stretch 50 clocks on the ACK of byte 2, plus an ignored start
    bb = bus_q.size(); b1 = busy1_cnt; st0 = n_start;
    stretch_at = rel_cnt + 18;
    pulse_start1(1'b0, 7'h50, 8'h34, 8'h5C);
    repeat (100) @(negedge clk);
    pulse_start1(1'b1, 7'h11, 8'hFF, 8'hFF);
    wait_done(1'b0, 2000, ok);
    check("st_done_seen", 32'(ok), 32'd1);
    repeat (40) @(negedge clk);
    stretch_at = -1;
    check("st_busy_cycles", 32'(busy1_cnt - b1), 32'd514);
    check("st_no_requeue", 32'(busy1), 32'd0);
    check("st_nack", 32'(nack1), 32'd0);
    check("st_starts", 32'(n_start - st0), 32'd1);
    exp_q.push_back(8'hA0); exp_q.push_back(8'h34); exp_q.push_back(8'h5C);
    check_bus("st", bb);

    // Reset while in WRITE, then a normal transaction
    d1 = done1_cnt;
    pulse_start1(1'b0, 7'h50, 8'h77, 8'h0F);
    repeat (339) @(negedge clk);
    check("ab_in_write", 32'(st1), 32'd4);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    check("ab_scl_rel", 32'(scl_oe1), 32'd0);
    check("ab_sda_rel", 32'(sda_oe1), 32'd0);
    check("ab_busy", 32'(busy1), 32'd0);
    check("ab_state", 32'(st1), 32'd0);
    repeat (40) @(negedge clk);
    check("ab_no_done", 32'(done1_cnt - d1), 32'd0);
    bb = bus_q.size(); b1 = busy1_cnt;
    pulse_start1(1'b0, 7'h50, 8'h21, 8'hC3);
    wait_done(1'b0, 2000, ok);
    check("ab2_done_seen", 32'(ok), 32'd1);
    repeat (4) @(negedge clk);
    check("ab2_busy_cycles", 32'(busy1_cnt - b1), 32'd464);
    check("ab2_nack", 32'(nack1), 32'd0);
    exp_q.push_back(8'hA0); exp_q.push_back(8'h21); exp_q.push_back(8'hC3);
    check_bus("ab2", bb);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/i2c_reg_master.md
I2C_REG_MASTER -- requirements
Module: i2c_reg_master

Interface
REQ-001 Parameter CLK_DIV, default 4: system clocks per SCL quarter-period; legal range 2..1023; SCL period = 4*CLK_DIV clocks.
REQ-002 Parameter ADDR_BYTES, default 1: register-address bytes sent per transaction; legal range 1..4.
REQ-003 Parameter DATA_BYTES, default 1: data bytes written or read per transaction; legal range 1..4.
REQ-004 clk  in  1  the only clock; every register in the block is clocked by it.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start_i  in  1  single-cycle transaction request; sampled only in IDLE.
REQ-007 rnw_i  in  1  1 = read transaction, 0 = write transaction; sampled with start_i.
REQ-008 dev_addr_i  in  7  7-bit I2C device address; sampled with start_i.
REQ-009 reg_addr_i  in  8*ADDR_BYTES  register address, sent MSB byte first; sampled with start_i.
REQ-010 wdata_i  in  8*DATA_BYTES  write data, sent MSB byte first; sampled with start_i.
REQ-011 rdata_o  out  8*DATA_BYTES  read data, first received byte in the MSB position.
REQ-012 busy_o  out  1  high while a transaction is in progress.
REQ-013 done_o  out  1  one-cycle pulse at transaction end.
REQ-014 nack_o  out  1  set when a slave NACK aborted the last transaction.
REQ-015 scl_i, sda_i  in  1 each  synchronised pad inputs.
REQ-016 scl_oe_o, sda_oe_o  out  1 each  open-drain controls; 1 = drive the line low, 0 = release it.

Function
REQ-017 State machine states: IDLE, START, ADDRESS, REGADDRESS, WRITE, RESTART, READ, ACK, MACK, STOP.
REQ-018 Each bit time is four quarters q0..q3; SCL is released in q2..q3; SDA changes only at the q0 boundary; SDA is sampled at the q2->q3 boundary.
REQ-019 START sequence: SDA low while SCL is high, then SCL low; RESTART: SDA released, SCL high, then START; STOP: SDA low, SCL high, then SDA released; each takes one bit time.
REQ-020 Write sequence: START, ADDRESS (dev_addr,0), ACK, ADDR_BYTES x (REGADDRESS, ACK), DATA_BYTES x (WRITE, ACK), STOP.
REQ-021 Read sequence: START, ADDRESS (dev_addr,0), ACK, ADDR_BYTES x (REGADDRESS, ACK), RESTART, ADDRESS (dev_addr,1), ACK, DATA_BYTES x (READ, MACK), STOP.
REQ-022 MACK drives ACK (SDA low) after every read byte except the last, which gets NACK (SDA released).
REQ-023 All bytes are sent MSB first.
REQ-024 A sampled SDA=1 in any ACK state sets nack_o=1 and jumps directly to STOP; the remaining bytes are skipped.
REQ-025 Clock stretching: while SCL is released and scl_i=0, the quarter counter holds, extending the high phase until scl_i=1.
REQ-026 busy_o rises in the cycle after start_i is accepted and falls together with the done_o pulse, which occurs on the clock after STOP completes.
REQ-027 nack_o clears when a new start_i is accepted; otherwise it holds until then.
REQ-028 rdata_o updates only at done_o of a read with nack_o=0; otherwise it holds its previous value.
REQ-029 start_i while busy_o=1 is ignored, with no queuing.
REQ-030 In IDLE, both scl_oe_o and sda_oe_o are 0.

Reset
REQ-031 rst=1 forces, at the next edge: IDLE, scl_oe_o=0, sda_oe_o=0, busy_o=0, done_o=0, nack_o=0, rdata_o=0, all counters 0.
REQ-032 Reset asserted mid-transaction releases both lines within one clock; no STOP is generated.

Verification
REQ-033 CLK_DIV=4, ADDR=1, DATA=1, write dev 0x50, reg 0x12, data 0xA5, slave ACKs -> bus bytes 0xA0, 0x12, 0xA5 then STOP; busy_o high for exactly 464 clocks; done_o=1 for 1 cycle; nack_o=0.
REQ-034 Read with ADDR=2, DATA=2, dev 0x50, reg 0x0102, slave returns 0xBE, 0xEF -> bus bytes 0xA0, 0x01, 0x02, RESTART, 0xA1; master ACK after 0xBE and NACK after 0xEF; rdata_o=0xBEEF at done_o.
REQ-035 Address NACK (no slave) -> STOP immediately after the first ACK slot; nack_o=1; rdata_o unchanged; no REGADDRESS bits appear on the bus.
REQ-036 Slave holds SCL low 50 clocks during the ACK of byte 2 -> the transaction stretches by exactly 50 clocks; data remains correct.
REQ-037 start_i pulsed while busy_o=1 -> ignored; reset during the WRITE state -> scl_oe_o=sda_oe_o=0 the next cycle, busy_o=0, and a new start_i is then accepted normally.
